// File: rtl/booth_pkg.sv
// Shared encodings and sizing helpers for the radix-4 Booth multiplier.
// BOOTH_SERIAL_OUT_EN adds the OUT_HI/OUT_LO half-word output states.
package booth_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INIT      = 3'd1;
    localparam logic [2:0] ST_ADD_SHIFT = 3'd2;
    localparam logic [2:0] ST_OUT_HI    = 3'd3;
    localparam logic [2:0] ST_OUT_LO    = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    localparam logic [2:0] DIG_ZERO = 3'd0;
    localparam logic [2:0] DIG_P1   = 3'd1;
    localparam logic [2:0] DIG_P2   = 3'd2;
    localparam logic [2:0] DIG_N1   = 3'd3;
    localparam logic [2:0] DIG_N2   = 3'd4;

    // One iteration per two bits of the (WIDTH+2)-bit extended multiplier.
    function automatic int booth_iters(input int width);
        return width / 2 + 1;
    endfunction

    function automatic int booth_cnt_w(input int width);
        return $clog2(booth_iters(width));
    endfunction

endpackage

// File: rtl/booth_r4_mult_if.sv
// Request/result bundle of booth_r4_mult; outbus exists only with
// BOOTH_SERIAL_OUT_EN defined.
interface booth_r4_mult_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       M;
    logic [WIDTH-1:0]       Q;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
`ifdef BOOTH_SERIAL_OUT_EN
    logic [WIDTH-1:0]       outbus;
`endif

    modport master (
        output start, is_signed, M, Q,
        input  busy, done, product
`ifdef BOOTH_SERIAL_OUT_EN
        , input outbus
`endif
    );

    modport slave (
        input  start, is_signed, M, Q,
        output busy, done, product
`ifdef BOOTH_SERIAL_OUT_EN
        , output outbus
`endif
    );
endinterface

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth digit recoding and accumulate: sum = A + digit * M,
// all in WIDTH+2 bits (wide enough that +-2M never overflows).
module booth_r4_recoder
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       triple,
    input  logic [WIDTH+1:0] m_ext,
    input  logic [WIDTH+1:0] a,
    output logic [WIDTH+1:0] sum
);
    logic [2:0]       digit;
    logic [WIDTH+1:0] m2;
    logic [WIDTH+1:0] addend;

    assign m2 = {m_ext[WIDTH:0], 1'b0};

    always_comb begin
        digit = DIG_ZERO;
        case (triple)
            3'b001, 3'b010: digit = DIG_P1;
            3'b011:         digit = DIG_P2;
            3'b100:         digit = DIG_N2;
            3'b101, 3'b110: digit = DIG_N1;
            default:        digit = DIG_ZERO;
        endcase
    end

    always_comb begin
        addend = '0;
        case (digit)
            DIG_P1:  addend = m_ext;
            DIG_P2:  addend = m2;
            DIG_N1:  addend = -m_ext;
            DIG_N2:  addend = -m2;
            default: addend = '0;
        endcase
    end

    assign sum = a + addend;

endmodule

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per operation.
// BOOTH_SERIAL_OUT_EN adds the half-word outbus port and its two states.
module booth_r4_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    booth_r4_mult_if.slave bus
);
    localparam int XW = WIDTH + 2;
    localparam int N  = booth_iters(WIDTH);
    localparam int CW = booth_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [2:0]         state_reg, state_next;
    logic [XW-1:0]      m_reg, a_reg, q_reg;
    logic               qm1_reg;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] product_reg;
`ifdef BOOTH_SERIAL_OUT_EN
    logic [WIDTH-1:0]   outbus_reg;
`endif

    logic [XW-1:0]      m_ext, q_ext;
    logic [XW-1:0]      sum, a_shift, q_shift;
    logic [2*WIDTH-1:0] product_next;
    logic               busy, done;

    assign m_ext = bus.is_signed ? {{2{bus.M[WIDTH-1]}}, bus.M} : {2'b00, bus.M};
    assign q_ext = bus.is_signed ? {{2{bus.Q[WIDTH-1]}}, bus.Q} : {2'b00, bus.Q};

    booth_r4_recoder #(.WIDTH(WIDTH)) u_recoder (
        .triple (q_reg[1:0] == 2'b00 && !qm1_reg ? 3'b000 : {q_reg[1:0], qm1_reg}),
        .m_ext  (m_reg),
        .a      (a_reg),
        .sum    (sum)
    );

    // Arithmetic shift of {A,Q,Q-1} by two; the low 2W bits of {A,Q} after
    // the final shift are the exact product in either mode.
    assign a_shift      = {{2{sum[XW-1]}}, sum[XW-1:2]};
    assign q_shift      = {sum[1:0], q_reg[XW-1:2]};
    assign product_next = {a_shift[WIDTH-3:0], q_shift};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:      state_next = bus.start ? ST_INIT : ST_IDLE;
            ST_INIT:      state_next = ST_ADD_SHIFT;
`ifdef BOOTH_SERIAL_OUT_EN
            ST_ADD_SHIFT: state_next = (count_reg == LAST) ? ST_OUT_HI : ST_ADD_SHIFT;
            ST_OUT_HI:    state_next = ST_OUT_LO;
            ST_OUT_LO:    state_next = ST_DONE;
`else
            ST_ADD_SHIFT: state_next = (count_reg == LAST) ? ST_DONE : ST_ADD_SHIFT;
`endif
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            ST_INIT, ST_ADD_SHIFT, ST_OUT_HI, ST_OUT_LO: busy = 1'b1;
            ST_DONE:                                     done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_reg       <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            qm1_reg     <= 1'b0;
            count_reg   <= '0;
            product_reg <= '0;
`ifdef BOOTH_SERIAL_OUT_EN
            outbus_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        m_reg <= m_ext;
                        q_reg <= q_ext;
                    end
                end
                ST_INIT: begin
                    a_reg     <= '0;
                    qm1_reg   <= 1'b0;
                    count_reg <= '0;
                end
                ST_ADD_SHIFT: begin
                    a_reg     <= a_shift;
                    q_reg     <= q_shift;
                    qm1_reg   <= q_reg[1];
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == LAST) begin
                        product_reg <= product_next;
`ifdef BOOTH_SERIAL_OUT_EN
                        outbus_reg  <= product_next[2*WIDTH-1:WIDTH];
`endif
                    end
                end
`ifdef BOOTH_SERIAL_OUT_EN
                ST_OUT_HI: outbus_reg <= product_reg[WIDTH-1:0];
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product_reg;
`ifdef BOOTH_SERIAL_OUT_EN
    assign bus.outbus  = outbus_reg;
`endif

endmodule

// File: tb/tb_booth_r4_mult.sv
// Directed bench for booth_r4_mult at WIDTH=8 and WIDTH=16; the serial
// half-word checks are included when BOOTH_SERIAL_OUT_EN is defined.
module tb_booth_r4_mult;

`ifdef BOOTH_SERIAL_OUT_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT8  = 5 + 2 + EXTRA;
    localparam int LAT16 = 9 + 2 + EXTRA;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    booth_r4_mult_if #(.WIDTH(8))  b8 ();
    booth_r4_mult_if #(.WIDTH(16)) b16 ();

    booth_r4_mult #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));
    booth_r4_mult #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          sgn;
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref16(input bit s, input logic [15:0] a, input logic [15:0] b);
        longint x, y, p;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({48'b0, a});
            y = longint'({48'b0, b});
        end
        p = x * y;
        return p[31:0];
    endfunction

    // Operands are scrambled right after acceptance to show they are not re-read.
    task automatic run8(input bit s, input logic [7:0] m, input logic [7:0] q,
                        output logic [15:0] prod, output int dcyc, output bit bok,
                        output logic [7:0] ohi, output logic [7:0] olo);
        bok = 1'b1; dcyc = -1; prod = '0; ohi = '0; olo = '0;
        @(negedge clk);
        b8.start = 1'b1; b8.is_signed = s; b8.M = m; b8.Q = q;
        @(posedge clk); #1;
        b8.start = 1'b0; b8.M = ~m; b8.Q = ~q; b8.is_signed = ~s;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
`ifdef BOOTH_SERIAL_OUT_EN
            if (c == LAT8 - 2) ohi = b8.outbus;
            if (c == LAT8 - 1) olo = b8.outbus;
`endif
            if (b8.done) begin
                dcyc = c;
                prod = b8.product;
                if (b8.busy) bok = 1'b0;
                break;
            end
            if (!b8.busy) bok = 1'b0;
        end
    endtask

    task automatic run16(input bit s, input logic [15:0] m, input logic [15:0] q,
                         output logic [31:0] prod, output int dcyc);
        dcyc = -1; prod = '0;
        @(negedge clk);
        b16.start = 1'b1; b16.is_signed = s; b16.M = m; b16.Q = q;
        @(posedge clk); #1;
        b16.start = 1'b0; b16.M = ~m; b16.Q = ~q;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (b16.done) begin
                dcyc = c;
                prod = b16.product;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [9];
        logic [15:0] p8, p1, p2;
        logic [31:0] p16;
        logic [7:0]  ohi, olo;
        logic [15:0] pats [5];
        int          dcyc, d1, d2, ndone;
        bit          bok;

        vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{1'b1, 8'h07, 8'hFD, 16'hFFEB};
        vecs[3] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[4] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        vecs[5] = '{1'b0, 8'hC8, 8'h03, 16'h0258};
        vecs[6] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[7] = '{1'b1, 8'h64, 8'hCE, 16'hEC78};
        vecs[8] = '{1'b0, 8'h0F, 8'h11, 16'h00FF};
        pats[0] = 16'h0000; pats[1] = 16'h0001; pats[2] = 16'hFFFF;
        pats[3] = 16'h7FFF; pats[4] = 16'h8000;

        reset = 1'b0;
        b8.start = 1'b0;  b8.is_signed = 1'b0;  b8.M = '0;  b8.Q = '0;
        b16.start = 1'b0; b16.is_signed = 1'b0; b16.M = '0; b16.Q = '0;
        repeat (3) @(negedge clk);
        check("reset_busy8", 64'(b8.busy), 64'd0);
        check("reset_done8", 64'(b8.done), 64'd0);
        check("reset_product8", 64'(b8.product), 64'd0);
        check("reset_product16", 64'(b16.product), 64'd0);
`ifdef BOOTH_SERIAL_OUT_EN
        check("reset_outbus8", 64'(b8.outbus), 64'd0);
`endif
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run8(vecs[i].sgn, vecs[i].m, vecs[i].q, p8, dcyc, bok, ohi, olo);
            $display("w8 vec%0d s=%0d %h*%h -> %h done@%0d", i, vecs[i].sgn, vecs[i].m, vecs[i].q, p8, dcyc);
            check($sformatf("w8_product[%0d]", i), 64'(p8), 64'(vecs[i].exp));
            check($sformatf("w8_done_cycle[%0d]", i), 64'(dcyc), 64'(LAT8));
            check($sformatf("w8_busy_window[%0d]", i), 64'(bok), 64'd1);
`ifdef BOOTH_SERIAL_OUT_EN
            check($sformatf("w8_outbus_hi[%0d]", i), 64'(ohi), 64'(vecs[i].exp[15:8]));
            check($sformatf("w8_outbus_lo[%0d]", i), 64'(olo), 64'(vecs[i].exp[7:0]));
`endif
        end

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    run16(s[0], pats[i], pats[j], p16, dcyc);
                    $display("w16 s=%0d %h*%h -> %h done@%0d", s, pats[i], pats[j], p16, dcyc);
                    check($sformatf("w16_product[%0d,%0d,%0d]", s, i, j), 64'(p16),
                          64'(ref16(s[0], pats[i], pats[j])));
                    check($sformatf("w16_done_cycle[%0d,%0d,%0d]", s, i, j), 64'(dcyc), 64'(LAT16));
                end
            end
        end

        // start held high: one operation per IDLE acceptance, mid-run operand change ignored
        d1 = -1; d2 = -1; ndone = 0; p1 = '0; p2 = '0;
        @(negedge clk);
        b8.start = 1'b1; b8.is_signed = 1'b1; b8.M = 8'h07; b8.Q = 8'hFD;
        @(posedge clk); #1;
        b8.M = 8'd100; b8.Q = 8'd5;
        for (int c = 1; c <= 3 * LAT8; c++) begin
            @(negedge clk);
            if (b8.done) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = c; p1 = b8.product;
                end else if (d2 < 0) begin
                    d2 = c; p2 = b8.product; b8.start = 1'b0;
                end
            end
        end
        b8.start = 1'b0;
        $display("hold-start: done@%0d p=%h, done@%0d p=%h, pulses=%0d", d1, p1, d2, p2, ndone);
        check("hold_first_done", 64'(d1), 64'(LAT8));
        check("hold_first_product", 64'(p1), 64'h0000_FFEB);
        check("hold_second_spacing", 64'(d2 - d1), 64'(LAT8 + 1));
        check("hold_second_product", 64'(p2), 64'h0000_01F4);
        check("hold_pulse_count", 64'(ndone), 64'd2);

        // reset in cycle 3 of a run aborts at once
        ndone = 0;
        @(negedge clk);
        b8.start = 1'b1; b8.is_signed = 1'b0; b8.M = 8'hFF; b8.Q = 8'hFF;
        @(posedge clk); #1;
        b8.start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        #1;
        $display("reset-abort: busy=%0d done=%0d product=%h", b8.busy, b8.done, b8.product);
        check("abort_busy", 64'(b8.busy), 64'd0);
        check("abort_done", 64'(b8.done), 64'd0);
        check("abort_product", 64'(b8.product), 64'd0);
        repeat (3) begin
            @(negedge clk);
            if (b8.done) ndone++;
        end
        reset = 1'b1;
        repeat (LAT8 + 2) begin
            @(negedge clk);
            if (b8.done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        check("abort_idle_busy", 64'(b8.busy), 64'd0);
        run8(1'b1, 8'h07, 8'hFD, p8, dcyc, bok, ohi, olo);
        $display("after-reset run: product=%h done@%0d", p8, dcyc);
        check("post_reset_product", 64'(p8), 64'h0000_FFEB);
        check("post_reset_done_cycle", 64'(dcyc), 64'(LAT8));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
